// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - IF stage control, redirect, program-load and status bundle
//
// Purpose: groups every signal of the fetch unit except clk/reset.
// master : the controlling side (pipeline control, debug/program loader, IF/ID consumer)
// slave  : the fetch unit itself
// Inputs to the fetch unit : clk_en, start, stall, branch_taken/branch_target,
//                            jump/jump_target, imem_wr_en/imem_wr_addr/imem_wr_data
// Outputs of the fetch unit: if_pc, if_pc_plus_4, if_instruction, halted, running,
//                            fetch_count
interface if_fetch_unit_if;
    logic        clk_en;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instruction;
    logic        halted;
    logic        running;
    logic [31:0] fetch_count;

    modport master (
        output clk_en, start, stall, branch_taken, branch_target, jump, jump_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        input  if_pc, if_pc_plus_4, if_instruction, halted, running, fetch_count
    );

    modport slave (
        input  clk_en, start, stall, branch_taken, branch_target, jump, jump_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        output if_pc, if_pc_plus_4, if_instruction, halted, running, fetch_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS instruction-fetch stage with PC, instruction memory and HALT detect
//
// Purpose: owns the PC and a word-addressed instruction memory, presents the fetched
// word and PC+4 to IF/ID every cycle, applies branch/jump redirects and stalls, stops
// on HALT_WORD and counts accepted fetches.
// Ports:
//   clk   - system clock, all state on the rising edge
//   reset - asynchronous active-high reset
//   bus   - if_fetch_unit_if.slave (control inputs, program-load port, fetch outputs)
module if_fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          reset,
    if_fetch_unit_if.slave bus
);
    localparam int          AW        = $clog2(IMEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(IMEM_DEPTH) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_count_q;
    logic [31:0] mem [IMEM_DEPTH];

    logic        rd_ok;
    logic        wr_ok;
    logic [31:0] instr;
    logic [31:0] pc_d;
    logic        halt_hit;
    logic        count_en;

    // Misaligned or out-of-range PCs fetch a NOP rather than aliasing into memory.
    assign rd_ok = ({1'b0, pc_q} < MEM_BYTES) && (pc_q[1:0] == 2'b00);
    assign wr_ok = ({1'b0, bus.imem_wr_addr} < MEM_BYTES);
    assign instr = (state_q == S_RUN && rd_ok) ? mem[pc_q[AW+1:2]] : 32'h0;

    // Next PC while running. Redirects win over stall, and a redirect in the same
    // cycle as a HALT_WORD fetch cancels the halt (that word sits in the branch shadow).
    always_comb begin
        pc_d     = pc_q;
        halt_hit = 1'b0;
        if (bus.branch_taken) begin
            pc_d = bus.branch_target;
        end else if (bus.jump) begin
            pc_d = bus.jump_target;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (instr == HALT_WORD) begin
            halt_hit = 1'b1;
        end else begin
            pc_d = pc_q + 32'd4;
        end
        count_en = !bus.stall && !halt_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= 32'h0;
            fetch_count_q <= 32'h0;
        end else if (bus.clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    pc_q <= pc_d;
                    if (count_en) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                    if (halt_hit) begin
                        state_q <= S_HALT;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Program load is only allowed while fetch is not running; not gated by clk_en
    // and not cleared by reset.
    always_ff @(posedge clk) begin
        if (bus.imem_wr_en && state_q != S_RUN && wr_ok) begin
            mem[bus.imem_wr_addr[AW+1:2]] <= bus.imem_wr_data;
        end
    end

    assign bus.if_pc          = pc_q;
    assign bus.if_pc_plus_4   = pc_q + 32'd4;
    assign bus.if_instruction = instr;
    assign bus.halted         = (state_q == S_HALT);
    assign bus.running        = (state_q == S_RUN);
    assign bus.fetch_count    = fetch_count_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          DEPTH = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cmp_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    if_fetch_unit_if bus();

    if_fetch_unit #(.IMEM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = run, 2 = halt
    logic [31:0] m_mem [DEPTH];
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_fetch();
        if (m_state != 1) return 32'h0;
        if (m_pc >= 32'(DEPTH * 4) || m_pc[1:0] != 2'b00) return 32'h0;
        return m_mem[m_pc[9:2]];
    endfunction

    always @(posedge reset) begin
        m_state = 0;
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
    end

    always @(posedge clk) begin
        int old_state;
        old_state = m_state;
        if (reset) begin
            m_state = 0;
            m_pc    = 32'h0;
            m_cnt   = 32'h0;
        end else if (bus.clk_en) begin
            if (m_state == 0) begin
                if (bus.start) m_state = 1;
            end else if (m_state == 1) begin
                if (bus.branch_taken || bus.jump) begin
                    m_pc = bus.branch_taken ? bus.branch_target : bus.jump_target;
                    if (!bus.stall) m_cnt = m_cnt + 1;
                end else if (bus.stall) begin
                    m_pc = m_pc;
                end else if (m_fetch() == HALT) begin
                    m_state = 2;
                end else begin
                    m_pc  = m_pc + 4;
                    m_cnt = m_cnt + 1;
                end
            end
        end
        if (bus.imem_wr_en && old_state != 1 && bus.imem_wr_addr < 32'(DEPTH * 4))
            m_mem[bus.imem_wr_addr[9:2]] = bus.imem_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("if_pc",          bus.if_pc,          m_pc);
            chk("if_pc_plus_4",   bus.if_pc_plus_4,   m_pc + 32'd4);
            chk("if_instruction", bus.if_instruction, m_fetch());
            chk("halted",         32'(bus.halted),    32'(m_state == 2));
            chk("running",        32'(bus.running),   32'(m_state == 1));
            chk("fetch_count",    bus.fetch_count,    m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.clk_en        = 1'b1;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        bus.imem_wr_en    = 1'b0;
        bus.imem_wr_addr  = 32'h0;
        bus.imem_wr_data  = 32'h0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        bus.jump        = 1'b1;
        bus.jump_target = tgt;
        tick();
        bus.jump        = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        cmp_en = 1'b1;

        // Reset state
        chk("rst_pc",     bus.if_pc,            32'h0);
        chk("rst_pc4",    bus.if_pc_plus_4,     32'h4);
        chk("rst_instr",  bus.if_instruction,   32'h0);
        chk("rst_halted", 32'(bus.halted),      32'h0);
        chk("rst_run",    32'(bus.running),     32'h0);
        chk("rst_cnt",    bus.fetch_count,      32'h0);

        // Program load in IDLE
        bus.imem_wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0)      w = 32'h2001_0005;
            else if (i == 1) w = 32'h2002_0007;
            else if (i == 2) w = HALT;
            else begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
            end
            bus.imem_wr_addr = 32'(i * 4);
            bus.imem_wr_data = w;
            tick();
        end
        bus.imem_wr_en = 1'b0;

        // Run to HALT
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("p0_pc",    bus.if_pc,          32'h0);
        chk("p0_instr", bus.if_instruction, 32'h2001_0005);
        tick();
        chk("p1_pc",    bus.if_pc,          32'h4);
        chk("p1_instr", bus.if_instruction, 32'h2002_0007);
        tick();
        chk("p2_pc",    bus.if_pc,          32'h8);
        chk("p2_instr", bus.if_instruction, HALT);
        tick();
        chk("h_halted", 32'(bus.halted),    32'h1);
        chk("h_pc",     bus.if_pc,          32'h8);
        chk("h_instr",  bus.if_instruction, 32'h0);
        chk("h_cnt",    bus.fetch_count,    32'h2);
        tick();
        chk("h2_pc",    bus.if_pc,          32'h8);

        // Stall for two cycles at PC 4
        pulse_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("s0_pc", bus.if_pc, 32'h4);
        bus.stall = 1'b1;
        tick();
        chk("s1_pc", bus.if_pc, 32'h4);
        tick();
        chk("s2_pc",  bus.if_pc,       32'h4);
        chk("s2_cnt", bus.fetch_count, 32'h1);
        bus.stall = 1'b0;
        tick();
        chk("s3_pc",    bus.if_pc,          32'h8);
        chk("s3_instr", bus.if_instruction, HALT);

        // Branch in the shadow of HALT_WORD cancels the halt
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h20;
        tick();
        bus.branch_taken  = 1'b0;
        chk("b_pc",     bus.if_pc,       32'h20);
        chk("b_halted", 32'(bus.halted), 32'h0);
        chk("b_cnt",    bus.fetch_count, 32'h3);

        // Branch beats jump beats stall
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h80;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h40;
        bus.stall         = 1'b1;
        tick();
        clear_inputs();
        chk("pri_pc", bus.if_pc, 32'h80);

        // Write during RUN ignored; out-of-range and misaligned fetches read 0
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = 32'h0;
        bus.imem_wr_data = 32'hDEAD_BEEF;
        tick();
        bus.imem_wr_en   = 1'b0;
        do_jump(32'h400);
        chk("oor_instr", bus.if_instruction, 32'h0);
        do_jump(32'hFFFF_FFFC);
        chk("wrap_pc4",  bus.if_pc_plus_4,   32'h0);
        do_jump(32'h6);
        chk("mis_instr", bus.if_instruction, 32'h0);

        // Asynchronous reset mid-RUN
        do_jump(32'h1C);
        chk("ar_pre_pc", bus.if_pc, 32'h1C);
        reset = 1'b1;
        #1;
        chk("ar_pc",  bus.if_pc,        32'h0);
        chk("ar_run", 32'(bus.running), 32'h0);
        chk("ar_cnt", bus.fetch_count,  32'h0);
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ret_instr", bus.if_instruction, 32'h2001_0005);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                reset = 1'b1;
            end
            bus.clk_en        = ($urandom_range(0, 99) < 80);
            bus.start         = ($urandom_range(0, 99) < 30);
            bus.stall         = ($urandom_range(0, 99) < 20);
            bus.branch_taken  = ($urandom_range(0, 99) < 10);
            bus.jump          = ($urandom_range(0, 99) < 10);
            bus.branch_target = ($urandom_range(0, 9) == 0) ? 32'($urandom)
                                                            : 32'($urandom_range(0, 300) * 4);
            bus.jump_target   = ($urandom_range(0, 9) == 0) ? 32'($urandom)
                                                            : 32'($urandom_range(0, 300) * 4);
            bus.imem_wr_en    = ($urandom_range(0, 99) < 15);
            bus.imem_wr_addr  = 32'($urandom_range(0, 511) * 4);
            bus.imem_wr_data  = ($urandom_range(0, 99) < 5) ? HALT : 32'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
